// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates UART receiver bytes, applies a parity drop policy,
// buffers accepted bytes in a FWFT FIFO and detects end-of-message by idle-gap timing.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int GAP_BITS     = 20,
  parameter int DEPTH        = 8,
  parameter bit DROP_BAD     = 1'b1,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_enable,
  input  logic          i_data_avail,
  input  logic [7:0]    i_data_byte,
  input  logic          i_parity_err,
  input  logic          i_clear,
  input  logic          i_flush,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [7:0]    o_data,
  output logic          o_data_err,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_frame_end,
  output logic          o_overflow,
  output logic [7:0]    o_err_cnt,
  output logic [1:0]    o_dbg_state
);

  localparam int          AW       = CW - 1;
  localparam logic [15:0] GAP_LAST = 16'(CLKS_PER_BIT * GAP_BITS - 1);

  typedef enum logic [1:0] {
    ST_OFF        = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_IN_FRAME   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Consumer handshake: o_valid means the head entry on o_data/o_data_err is
  // meaningful; the entry is consumed on a rising clk edge where o_valid and
  // i_ready are both 1. o_valid never depends on i_ready.
  // ---------------------------------------------------------------------------

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [7:0]    r_err_cnt;
  state_t        r_state;
  logic [15:0]   r_gap;

  logic          w_event;
  logic          w_push_req;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_err_inc;
  logic          w_entry_err;
  logic [8:0]    w_head;
  state_t        w_state_nxt;
  logic [15:0]   w_gap_nxt;
  logic          w_frame_end;

  assign w_event     = i_enable & i_data_avail;
  assign w_push_req  = w_event & ~(DROP_BAD & i_parity_err);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  // Flush wins over everything touching the FIFO in the same cycle.
  assign w_pop       = ~w_empty & i_ready & ~i_flush;
  assign w_push      = w_push_req & (~w_full | w_pop) & ~i_flush;
  assign w_ovf_set   = w_push_req & w_full & ~w_pop & ~i_flush;
  assign w_err_inc   = w_event & i_parity_err & (r_err_cnt != 8'hFF);
  assign w_entry_err = DROP_BAD ? 1'b0 : i_parity_err;

  // Storage carries no reset; only pointer/count state defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_entry_err, i_data_byte};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Status: clear has priority over a same-cycle set or increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else if (i_clear) begin
      r_overflow <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
      if (w_err_inc) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_OFF;
      r_gap   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // Gap counts cycles since the last byte event; reaching GAP_LAST is exactly
  // GAP_CLKS cycles after that event, so the pulse needs no extra register.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_frame_end = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_OFF;
      w_gap_nxt   = 16'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_WAIT_FIRST;
          w_gap_nxt   = 16'd0;
        end
        ST_WAIT_FIRST: begin
          w_gap_nxt = 16'd0;
          if (w_event) begin
            w_state_nxt = ST_IN_FRAME;
          end
        end
        ST_IN_FRAME: begin
          if (w_event) begin
            w_gap_nxt = 16'd0;
          end else if (r_gap == GAP_LAST) begin
            w_frame_end = 1'b1;
            w_state_nxt = ST_WAIT_FIRST;
            w_gap_nxt   = 16'd0;
          end else begin
            w_gap_nxt = r_gap + 16'd1;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_gap_nxt   = 16'd0;
        end
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_valid     = ~w_empty;
  assign o_data      = w_head[7:0];
  assign o_data_err  = DROP_BAD ? 1'b0 : w_head[8];
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_frame_end = w_frame_end;
  assign o_overflow  = r_overflow;
  assign o_err_cnt   = r_err_cnt;
  assign o_dbg_state = r_state;

endmodule
